// File: rtl/branch_unit.sv
// Branch resolution for the KGP-RISC datapath.
// Decodes opcodes 48-59 against ALU flags; all outputs registered.
module branch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [25:0] label,
  input  logic [31:0] rsVal,
  input  logic        carryFlag,
  input  logic        zFlag,
  input  logic        overflowFlag,
  input  logic        signFlag,
  input  logic [11:0] pc,
  input  logic [31:0] raDataOld,
  output logic [31:0] raDataNew,
  output logic [25:0] pcLabel,
  output logic        isBranch
);

  localparam logic [5:0] OP_B    = 6'd48;
  localparam logic [5:0] OP_BR   = 6'd49;
  localparam logic [5:0] OP_BZ   = 6'd50;
  localparam logic [5:0] OP_BNZ  = 6'd51;
  localparam logic [5:0] OP_BCY  = 6'd52;
  localparam logic [5:0] OP_BNCY = 6'd53;
  localparam logic [5:0] OP_BS   = 6'd54;
  localparam logic [5:0] OP_BNS  = 6'd55;
  localparam logic [5:0] OP_BV   = 6'd56;
  localparam logic [5:0] OP_BNV  = 6'd57;
  localparam logic [5:0] OP_CALL = 6'd58;
  localparam logic [5:0] OP_RET  = 6'd59;

  logic        w_taken;
  logic [25:0] w_target;
  logic [31:0] w_ra;
  logic [31:0] w_ret_addr;

  logic [31:0] r_ra;
  logic [25:0] r_label;
  logic        r_branch;

  // Zero-extend before adding so the carry out of pc[11] survives.
  assign w_ret_addr = {20'b0, pc} + 32'd4;

  always_comb begin
    w_taken  = 1'b0;
    w_target = label;
    w_ra     = raDataOld;
    unique case (opcode)
      OP_B:    w_taken = 1'b1;
      OP_BR: begin
        w_taken  = 1'b1;
        w_target = rsVal[25:0];
      end
      OP_BZ:   w_taken = zFlag;
      OP_BNZ:  w_taken = ~zFlag;
      OP_BCY:  w_taken = carryFlag;
      OP_BNCY: w_taken = ~carryFlag;
      OP_BS:   w_taken = signFlag;
      OP_BNS:  w_taken = ~signFlag;
      OP_BV:   w_taken = overflowFlag;
      OP_BNV:  w_taken = ~overflowFlag;
      OP_CALL: begin
        w_taken = 1'b1;
        w_ra    = w_ret_addr;
      end
      OP_RET: begin
        w_taken  = 1'b1;
        w_target = raDataOld[25:0];
      end
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch <= 1'b0;
      r_label  <= '0;
      r_ra     <= '0;
    end else begin
      r_branch <= w_taken;
      r_label  <= w_taken ? w_target : 26'd0;
      r_ra     <= w_ra;
    end
  end

  assign isBranch  = r_branch;
  assign pcLabel   = r_label;
  assign raDataNew = r_ra;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: directed plan cases plus random
// stimulus against an opcode-table reference model.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic [25:0] label;
  logic [31:0] rsVal;
  logic        carryFlag, zFlag, overflowFlag, signFlag;
  logic [11:0] pc;
  logic [31:0] raDataOld;
  logic [31:0] raDataNew;
  logic [25:0] pcLabel;
  logic        isBranch;

  typedef struct {
    logic        br;
    logic [25:0] lbl;
    logic [31:0] ra;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .label(label),
    .rsVal(rsVal), .carryFlag(carryFlag), .zFlag(zFlag),
    .overflowFlag(overflowFlag), .signFlag(signFlag), .pc(pc),
    .raDataOld(raDataOld), .raDataNew(raDataNew),
    .pcLabel(pcLabel), .isBranch(isBranch)
  );

  function automatic exp_t model(bit r, int op, longint lab,
                                 longint rs, bit c, bit z, bit v,
                                 bit s, int pcv, longint raold);
    exp_t   e;
    bit     fl[4];
    bit     taken;
    longint tgt;
    longint ra;
    int     k;
    fl    = '{z, c, s, v};
    taken = 0;
    tgt   = lab;
    ra    = raold;
    if (op == 48) taken = 1;
    else if (op == 49) begin
      taken = 1;
      tgt   = rs % (64'd1 << 26);
    end else if (op >= 50 && op <= 57) begin
      k     = op - 50;
      taken = fl[k / 2] ^ bit'(k % 2);
    end else if (op == 58) begin
      taken = 1;
      ra    = pcv + 4;
    end else if (op == 59) begin
      taken = 1;
      tgt   = raold % (64'd1 << 26);
    end
    if (r) begin
      e.br = 0; e.lbl = 0; e.ra = 0;
    end else begin
      e.br  = taken;
      e.lbl = taken ? 26'(tgt) : 26'd0;
      e.ra  = 32'(ra);
    end
    return e;
  endfunction

  task automatic drive(bit r, int op, logic [25:0] lab,
                       logic [31:0] rs, bit c, bit z, bit v,
                       bit s, logic [11:0] pcv, logic [31:0] raold);
    @(negedge clk);
    rst = r; opcode = 6'(op); label = lab; rsVal = rs;
    carryFlag = c; zFlag = z; overflowFlag = v; signFlag = s;
    pc = pcv; raDataOld = raold;
    q.push_back(model(r, op, lab, rs, c, z, v, s, pcv, raold));
  endtask

  // Monitor: one result per rising edge once stimulus is queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (isBranch !== e.br) begin
          errors++;
          $display("FAIL isBranch op=%0d got=%b exp=%b",
                   opcode, isBranch, e.br);
        end
        checks++;
        if (pcLabel !== e.lbl) begin
          errors++;
          $display("FAIL pcLabel got=%h exp=%h", pcLabel, e.lbl);
        end
        checks++;
        if (raDataNew !== e.ra) begin
          errors++;
          $display("FAIL raDataNew got=%h exp=%h", raDataNew, e.ra);
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1; opcode = 0; label = 0; rsVal = 0;
    carryFlag = 0; zFlag = 0; overflowFlag = 0; signFlag = 0;
    pc = 0; raDataOld = 0;

    drive(1, 48, 36, 0, 0, 0, 0, 0, 4, 32'h55);
    drive(0, 48, 36, 0, 0, 0, 0, 0, 4, 32'h55);
    drive(0, 49, 36, 36, 0, 0, 0, 0, 4, 32'h77);
    drive(0, 49, 36, 32'hFC00_0024, 0, 0, 0, 0, 4, 32'h77);
    // flag sweep: (c,z,v,s) argument order
    drive(0, 50, 36, 0, 0, 1, 0, 0, 8, 1);
    drive(0, 52, 36, 0, 1, 0, 0, 0, 8, 1);
    drive(0, 54, 36, 0, 0, 0, 0, 1, 8, 1);
    drive(0, 56, 36, 0, 0, 0, 1, 0, 8, 1);
    drive(0, 51, 36, 0, 1, 0, 1, 1, 8, 1);
    drive(0, 53, 36, 0, 0, 1, 1, 1, 8, 1);
    drive(0, 55, 36, 0, 1, 1, 1, 0, 8, 1);
    drive(0, 57, 36, 0, 1, 1, 0, 1, 8, 1);
    drive(0, 50, 36, 0, 1, 0, 1, 1, 8, 1);
    drive(0, 52, 36, 0, 0, 1, 1, 1, 8, 1);
    drive(0, 54, 36, 0, 1, 1, 1, 0, 8, 1);
    drive(0, 56, 36, 0, 1, 1, 0, 1, 8, 1);
    drive(0, 51, 36, 0, 0, 1, 0, 0, 8, 1);
    drive(0, 53, 36, 0, 1, 0, 0, 0, 8, 1);
    drive(0, 55, 36, 0, 0, 0, 0, 1, 8, 1);
    drive(0, 57, 36, 0, 0, 0, 1, 0, 8, 1);
    drive(0, 58, 36, 0, 0, 0, 0, 0, 4, 0);
    drive(0, 58, 36, 0, 0, 0, 0, 0, 12'hFFC, 0);
    drive(0, 59, 36, 0, 0, 0, 0, 0, 4, 4);
    drive(0, 59, 36, 0, 0, 0, 0, 0, 4, 32'hFC00_1234);
    drive(0, 0, 36, 5, 1, 1, 1, 1, 4, 32'hABCD);
    drive(0, 63, 36, 5, 1, 1, 1, 1, 4, 32'h1234);
    drive(0, 48, 99, 0, 0, 0, 0, 0, 4, 9);
    drive(1, 48, 99, 0, 0, 0, 0, 0, 4, 9);
    drive(0, 58, 7, 0, 0, 0, 0, 0, 12'h123, 9);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 19) == 0), $urandom_range(40, 63),
            26'($urandom), $urandom, 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 12'($urandom), $urandom);
    end

    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Branch resolution unit of the KGP-RISC datapath.
- Decodes branch opcodes 48–59 and evaluates the condition against the ALU status flags.
- Produces the taken flag, the 26-bit target address and the updated return-address (ra) register value.
- Sits between decode/ALU flag state and PC-update logic; all outputs are registered.

Parameters:
- none (all widths fixed: opcode 6, label/target 26, data 32, pc 12)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  6  instruction opcode
- label  input  26  immediate branch target from instruction
- rsVal  input  32  value of register rs (register-indirect branch)
- carryFlag  input  1  ALU carry flag
- zFlag  input  1  ALU zero flag
- overflowFlag  input  1  ALU overflow flag
- signFlag  input  1  ALU sign flag
- pc  input  12  address of current instruction
- raDataOld  input  32  current contents of ra register
- raDataNew  output  32  value to write back to ra
- pcLabel  output  26  branch target address
- isBranch  output  1  1 = branch taken, PC must load pcLabel

Behaviour:
- Registered outputs, 1-cycle latency.
  - Inputs sampled at rising clk; outputs valid after that edge and held until the next edge.
- Reset: if rst=1 at a rising edge, isBranch<=0, pcLabel<=0, raDataNew<=0. Reset has priority over all opcodes.
- Opcode decode (taken condition / target):
  - 48 b: always taken, target=label
  - 49 br: always taken, target=rsVal[25:0]
  - 50 bz: taken if zFlag=1, target=label
  - 51 bnz: taken if zFlag=0, target=label
  - 52 bcy: taken if carryFlag=1, target=label
  - 53 bncy: taken if carryFlag=0, target=label
  - 54 bs: taken if signFlag=1, target=label
  - 55 bns: taken if signFlag=0, target=label
  - 56 bv: taken if overflowFlag=1, target=label
  - 57 bnv: taken if overflowFlag=0, target=label
  - 58 call: always taken, target=label, raDataNew={20'b0,pc}+4
  - 59 ret: always taken, target=raDataOld[25:0]
  - any other opcode: not a branch, isBranch=0
- pcLabel is 0 whenever isBranch=0 (not-taken conditional or non-branch opcode).
- raDataNew equals raDataOld for every opcode except call.
- Call arithmetic: pc is zero-extended to 32 bits before adding 4, so the carry out of bit 11 is kept (pc=12'hFFC -> 32'h00001000).
- rsVal[31:26] and raDataOld[31:26] are ignored when forming a target.
- Flags irrelevant to the current opcode have no effect.
- Purely per-cycle operation: no internal state besides the output registers; back-to-back branches each resolve independently.

Test Plan:
- rst=1 for one edge with opcode=48 -> isBranch=0, pcLabel=0, raDataNew=0; deassert rst, opcode=48, label=36, pc=4 -> next edge isBranch=1, pcLabel=36, raDataNew=raDataOld.
- opcode=49, rsVal=36, label=36 -> isBranch=1, pcLabel=36; repeat with rsVal=32'hFC00_0024 -> pcLabel=36 (upper bits dropped).
- Flag sweep opcodes 50–57 with label=36:
  - 50/z=1, 52/c=1, 54/s=1, 56/v=1 -> taken, pcLabel=36
  - 51/z=0, 53/c=0, 55/s=0, 57/v=0 -> taken
  - each opcode with its flag inverted -> isBranch=0, pcLabel=0
- opcode=58, label=36, pc=4, raDataOld=0 -> isBranch=1, pcLabel=36, raDataNew=8; pc=12'hFFC -> raDataNew=32'h1000.
- opcode=59, raDataOld=4 -> isBranch=1, pcLabel=4, raDataNew=4.
- opcode=0 and opcode=63 with all flags set -> isBranch=0, pcLabel=0, raDataNew=raDataOld; assert rst mid-sequence during a taken branch -> outputs cleared at that edge.
